// File: rtl/sal_ref_ctrl.sv
// sal_ref_ctrl: DDR2 periodic refresh scheduler.
// Counts tREFI, accumulates owed refreshes, runs a req/gnt handshake with the
// bank controller and blocks further requests for tRFC after each grant.
// Build option SAL_REF_POSTPONE_EN: when defined, up to MAX_PEND refreshes may
// be owed and ref_urgent_o tracks pend >= URGENT_TH. When undefined, at most
// one refresh is owed and ref_urgent_o mirrors ref_req_o.
//
// state | meaning
// IDLE  | no request outstanding
// REQ   | ref_req_o high, waiting for ref_gnt_i
// RFC   | REF issued, tRFC hold-off running (ref_busy_o high)

module sal_ref_ctrl #(
   parameter int TREFI_W   = 16,
   parameter int TRFC_W    = 8,
   parameter int MAX_PEND  = 8,
   parameter int URGENT_TH = 6
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          ref_en_i,
   input  logic [TREFI_W-1:0]            trefi_i,
   input  logic [TRFC_W-1:0]             trfc_i,
   output logic                          ref_req_o,
   input  logic                          ref_gnt_i,
   output logic                          ref_urgent_o,
   output logic                          ref_busy_o,
   output logic [$clog2(MAX_PEND):0]     ref_pend_o,
   output logic                          ref_ovf_o
);

   localparam int PW = $clog2(MAX_PEND) + 1;

`ifdef SAL_REF_POSTPONE_EN
   localparam logic [PW-1:0] PEND_MAX = PW'(MAX_PEND);
   localparam logic [PW-1:0] URG_TH   = PW'(URGENT_TH);
`else
   localparam logic [PW-1:0] PEND_MAX = PW'(1);
`endif

   typedef enum logic [1:0] {IDLE, REQ, RFC} state_t;

   state_t              state;
   logic [TREFI_W-1:0]  icnt;
   logic [TRFC_W-1:0]   rcnt;
   logic [PW-1:0]       pend;
   logic [PW-1:0]       pend_nxt;
   logic                run;
   logic                tick;
   logic                gnt_acc;
   logic                ovf_set;

   assign run     = ref_en_i && (trefi_i != '0);
   assign tick    = run && (icnt == '0);
   assign gnt_acc = (state == REQ) && ref_gnt_i;

   assign ref_pend_o = pend;

   // Interval down-counter; parks at trefi-1 while idle so the first tick
   // lands trefi cycles after enable.
   always_ff @(posedge clk) begin
      if (rst) begin
         icnt <= '0;
      end else if (!run || (icnt == '0)) begin
         icnt <= (trefi_i == '0) ? '0 : trefi_i - TREFI_W'(1);
      end else begin
         icnt <= icnt - TREFI_W'(1);
      end
   end

   // Next owed-refresh count; a simultaneous tick and grant cancel out.
   always_comb begin
      pend_nxt = pend;
      ovf_set  = 1'b0;
      if (!ref_en_i) begin
         pend_nxt = '0;
      end else if (tick && !gnt_acc) begin
         if (pend == PEND_MAX) ovf_set  = 1'b1;
         else                  pend_nxt = pend + PW'(1);
      end else if (gnt_acc && !tick && (pend != '0)) begin
         pend_nxt = pend - PW'(1);
      end
   end

   // Owed-refresh register, sticky overflow and (when postponing) urgency.
   always_ff @(posedge clk) begin
      if (rst) begin
         pend      <= '0;
         ref_ovf_o <= 1'b0;
`ifdef SAL_REF_POSTPONE_EN
         ref_urgent_o <= 1'b0;
`endif
      end else begin
         pend <= pend_nxt;
         if (ovf_set) ref_ovf_o <= 1'b1;
`ifdef SAL_REF_POSTPONE_EN
         ref_urgent_o <= (pend_nxt >= URG_TH);
`endif
      end
   end

`ifndef SAL_REF_POSTPONE_EN
   assign ref_urgent_o = ref_req_o;
`endif

   // Handshake FSM with registered req/busy and the tRFC down-counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         rcnt       <= '0;
         ref_req_o  <= 1'b0;
         ref_busy_o <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if ((pend != '0) && ref_en_i) begin
                  state     <= REQ;
                  ref_req_o <= 1'b1;
               end
            end
            REQ: begin
               if (ref_gnt_i) begin
                  state      <= RFC;
                  ref_req_o  <= 1'b0;
                  ref_busy_o <= 1'b1;
                  rcnt       <= (trfc_i == '0) ? TRFC_W'(1) : trfc_i;
               end else if (!ref_en_i) begin
                  state     <= IDLE;
                  ref_req_o <= 1'b0;
               end
            end
            RFC: begin
               if (rcnt <= TRFC_W'(1)) begin
                  state      <= IDLE;
                  ref_busy_o <= 1'b0;
               end else begin
                  rcnt <= rcnt - TRFC_W'(1);
               end
            end
            default: begin
               state      <= IDLE;
               ref_req_o  <= 1'b0;
               ref_busy_o <= 1'b0;
            end
         endcase
      end
   end

endmodule
